serial_link_bringup_seq: RTL and testbench

- Hardware sequencer that brings one serial link instance out of reset.
- Acts as a RegBus master on the link's cfg port and replaces software-driven bring-up.
- Runs a fixed sequence: reset and clock-gate writes, channel-allocator configuration, a settle delay, AXI de-isolation, then polls the ISOLATED register until it reads 0.
- Sits directly upstream of the link's cfg port, on the register clock domain.

---
 rtl/serial_link_bringup_seq.sv | 188 ++++++++++++++++++
 tb/tb_serial_link_bringup_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_bringup_seq.sv
// Bring-up sequencer for one serial link instance. It acts as a RegBus master on the
// link's cfg port: it releases reset, enables the clock, configures the channel
// allocator, waits a settle time, removes AXI isolation, then polls ISOLATED until
// it reads clear.
`timescale 1ns/1ps
module serial_link_bringup_seq #(
   parameter int unsigned RegAddrWidth = 32,
   parameter int unsigned RegDataWidth = 32,
   parameter logic [RegAddrWidth-1:0] CtrlOffset       = 32'h0,
   parameter logic [RegAddrWidth-1:0] IsolatedOffset   = 32'h4,
   parameter logic [RegAddrWidth-1:0] AllocTxCfgOffset = 32'h10,
   parameter logic [RegAddrWidth-1:0] AllocRxCfgOffset = 32'h20,
   parameter int unsigned WaitCycles = 50,
   parameter int unsigned MaxPolls   = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   output logic [RegAddrWidth-1:0]   cfg_addr_o,
   output logic                      cfg_write_o,
   output logic [RegDataWidth-1:0]   cfg_wdata_o,
   output logic [RegDataWidth/8-1:0] cfg_wstrb_o,
   output logic                      cfg_valid_o,
   input  logic [RegDataWidth-1:0]   cfg_rdata_i,
   input  logic                      cfg_error_i,
   input  logic                      cfg_ready_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [1:0]                err_code_o
);

   localparam int unsigned PollW = $clog2(MaxPolls + 1);
   localparam int unsigned WaitW = $clog2(WaitCycles + 1);
   localparam logic [PollW-1:0] PollLast = PollW'(MaxPolls - 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(WaitCycles - 1);

   localparam logic [RegDataWidth-1:0] CtrlRst0  = RegDataWidth'(32'h300);
   localparam logic [RegDataWidth-1:0] CtrlRst1  = RegDataWidth'(32'h302);
   localparam logic [RegDataWidth-1:0] CtrlClkEn = RegDataWidth'(32'h303);
   localparam logic [RegDataWidth-1:0] CtrlDeiso = RegDataWidth'(32'h003);
   localparam logic [RegDataWidth-1:0] AllocCfg  = RegDataWidth'(32'h3);

   localparam logic [1:0] ErrBus     = 2'd1;
   localparam logic [1:0] ErrTimeout = 2'd2;

   typedef enum logic [3:0] {
      StIdle, StWRst0, StWRst1, StWClkEn, StWTx, StWRx, StWait, StWDeiso, StRIso, StDone, StErr
   } state_e;

   state_e                      state_q;
   logic [RegAddrWidth-1:0]     addr_q;
   logic                        write_q;
   logic [RegDataWidth-1:0]     wdata_q;
   logic [RegDataWidth/8-1:0]   wstrb_q;
   logic                        valid_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        error_q;
   logic [1:0]                  err_code_q;
   logic [PollW-1:0]            poll_cnt_q;
   logic [WaitW-1:0]            wait_cnt_q;

   // Only the two isolation status bits of ISOLATED are meaningful.
   logic unused_rdata;
   assign unused_rdata = ^cfg_rdata_i[RegDataWidth-1:2];

   // Sequencer FSM; every output is a flop updated here.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '1;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'd0;
         poll_cnt_q <= '0;
         wait_cnt_q <= '0;
      end else begin
         wstrb_q <= '1;
         unique case (state_q)
            StIdle, StDone, StErr: begin
               if (start_i) begin
                  state_q    <= StWRst0;
                  valid_q    <= 1'b1;
                  write_q    <= 1'b1;
                  addr_q     <= CtrlOffset;
                  wdata_q    <= CtrlRst0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  err_code_q <= 2'd0;
                  poll_cnt_q <= '0;
                  wait_cnt_q <= '0;
               end
            end
            StWait: begin
               if (wait_cnt_q == WaitLast) begin
                  state_q <= StWDeiso;
                  valid_q <= 1'b1;
                  write_q <= 1'b1;
                  addr_q  <= CtrlOffset;
                  wdata_q <= CtrlDeiso;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end
            end
            default: begin
               // Request states: advance only on a completed handshake.
               if (valid_q && cfg_ready_i) begin
                  if (cfg_error_i) begin
                     state_q    <= StErr;
                     valid_q    <= 1'b0;
                     busy_q     <= 1'b0;
                     error_q    <= 1'b1;
                     err_code_q <= ErrBus;
                  end else begin
                     case (state_q)
                        StWRst0: begin
                           state_q <= StWRst1;
                           wdata_q <= CtrlRst1;
                        end
                        StWRst1: begin
                           state_q <= StWClkEn;
                           wdata_q <= CtrlClkEn;
                        end
                        StWClkEn: begin
                           state_q <= StWTx;
                           addr_q  <= AllocTxCfgOffset;
                           wdata_q <= AllocCfg;
                        end
                        StWTx: begin
                           state_q <= StWRx;
                           addr_q  <= AllocRxCfgOffset;
                        end
                        StWRx: begin
                           state_q    <= StWait;
                           valid_q    <= 1'b0;
                           wait_cnt_q <= '0;
                        end
                        StWDeiso: begin
                           state_q <= StRIso;
                           write_q <= 1'b0;
                           addr_q  <= IsolatedOffset;
                           wdata_q <= '0;
                        end
                        StRIso: begin
                           if (cfg_rdata_i[1:0] == 2'b00) begin
                              state_q <= StDone;
                              valid_q <= 1'b0;
                              busy_q  <= 1'b0;
                              done_q  <= 1'b1;
                           end else begin
                              poll_cnt_q <= poll_cnt_q + PollW'(1);
                              // Reads reissue back-to-back until the poll budget is spent.
                              if (poll_cnt_q == PollLast) begin
                                 state_q    <= StErr;
                                 valid_q    <= 1'b0;
                                 busy_q     <= 1'b0;
                                 error_q    <= 1'b1;
                                 err_code_q <= ErrTimeout;
                              end
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign cfg_addr_o  = addr_q;
   assign cfg_write_o = write_q;
   assign cfg_wdata_o = wdata_q;
   assign cfg_wstrb_o = wstrb_q;
   assign cfg_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_serial_link_bringup_seq.sv
// Scoreboard bench for serial_link_bringup_seq: a reference model queues the expected
// RegBus transactions per run; a slave/monitor process answers and checks them.
`timescale 1ns/1ps
module tb_serial_link_bringup_seq;

   localparam int unsigned Wait  = 50;
   localparam int unsigned Polls = 6;
   localparam logic [31:0] ACtrl = 32'h0;
   localparam logic [31:0] AIso  = 32'h4;
   localparam logic [31:0] ATx   = 32'h10;
   localparam logic [31:0] ARx   = 32'h20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] addr;
   logic        write;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        valid;
   logic [31:0] rdata;
   logic        err;
   logic        ready;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  code;

   always #5 clk = ~clk;

   serial_link_bringup_seq #(
      .RegAddrWidth    (32),
      .RegDataWidth    (32),
      .CtrlOffset      (ACtrl),
      .IsolatedOffset  (AIso),
      .AllocTxCfgOffset(ATx),
      .AllocRxCfgOffset(ARx),
      .WaitCycles      (Wait),
      .MaxPolls        (Polls)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .cfg_addr_o (addr),
      .cfg_write_o(write),
      .cfg_wdata_o(wdata),
      .cfg_wstrb_o(wstrb),
      .cfg_valid_o(valid),
      .cfg_rdata_i(rdata),
      .cfg_error_i(err),
      .cfg_ready_i(ready),
      .busy_o     (busy),
      .done_o     (done),
      .error_o    (error),
      .err_code_o (code)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } txn_t;

   txn_t exp_q[$];
   int n_chk = 0;
   int n_fail = 0;

   // Per-run slave behaviour.
   int cfg_wmode = 0;   // fixed wait states per txn, -1 = random 0..3
   int cfg_err_at = -1; // txn index answered with error
   int cfg_nnz = 0;     // ISOLATED reads returning nonzero before a zero

   int hs_idx = 0;
   int low_cnt = 0;
   int vh_cnt = 0;
   bit in_txn = 0;
   int cur_wait = 0;
   int wcnt = 0;

   logic        prev_valid = 1'b0;
   logic        prev_hs = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;
   logic        prev_write = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference sequence: five config writes, de-isolation write, then ISOLATED reads.
   function automatic txn_t model_txn(input int i);
      txn_t t;
      case (i)
         0:       t = '{addr: ACtrl, wr: 1'b1, data: 32'h300};
         1:       t = '{addr: ACtrl, wr: 1'b1, data: 32'h302};
         2:       t = '{addr: ACtrl, wr: 1'b1, data: 32'h303};
         3:       t = '{addr: ATx,   wr: 1'b1, data: 32'h3};
         4:       t = '{addr: ARx,   wr: 1'b1, data: 32'h3};
         5:       t = '{addr: ACtrl, wr: 1'b1, data: 32'h003};
         default: t = '{addr: AIso,  wr: 1'b0, data: 32'h0};
      endcase
      return t;
   endfunction

   // Slave and monitor share the falling edge: decide ready, then score the handshake.
   always @(negedge clk) begin : slave_mon
      bit          hs;
      logic [31:0] r;
      txn_t        e;
      hs = 1'b0;
      if (valid) begin
         if (!in_txn) begin
            in_txn   = 1'b1;
            cur_wait = (cfg_wmode >= 0) ? cfg_wmode : int'($urandom_range(0, 3));
            wcnt     = 0;
         end
         if (wcnt == cur_wait) begin
            hs     = 1'b1;
            in_txn = 1'b0;
         end else begin
            wcnt++;
         end
      end
      ready = hs ? 1'b1 : (valid ? 1'b0 : 1'($urandom_range(0, 1)));
      err   = hs ? (hs_idx == cfg_err_at) : 1'($urandom_range(0, 1));
      r = 32'($urandom);
      if (hs && hs_idx >= 6) begin
         r = r & 32'hFFFF_FFFC;
         if (hs_idx - 6 < cfg_nnz) r = r | 32'($urandom_range(1, 3));
      end
      rdata = r;

      if (valid) vh_cnt++;
      if (valid && prev_valid && !prev_hs) begin
         check("stable_addr", addr, prev_addr);
         check("stable_write", write, prev_write);
         check("stable_wdata", wdata, prev_wdata);
      end
      if (hs) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_txn: got addr 0x%0h, expected no transaction", addr);
         end else begin
            e = exp_q.pop_front();
            check("txn_addr", addr, e.addr);
            check("txn_write", write, e.wr);
            if (e.wr) check("txn_wdata", wdata, e.data);
            check("valid_gap", low_cnt, (hs_idx == 5) ? Wait : 0);
         end
         hs_idx++;
         low_cnt = 0;
      end else if (!valid) begin
         low_cnt++;
      end
      prev_valid = valid;
      prev_hs    = hs;
      prev_addr  = addr;
      prev_write = write;
      prev_wdata = wdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string nm);
      check({nm, "_valid"}, valid, 1'b0);
      check({nm, "_write"}, write, 1'b0);
      check({nm, "_addr"}, addr, 32'h0);
      check({nm, "_wdata"}, wdata, 32'h0);
      check({nm, "_wstrb"}, wstrb, 4'hF);
      check({nm, "_busy"}, busy, 1'b0);
      check({nm, "_done"}, done, 1'b0);
      check({nm, "_error"}, error, 1'b0);
      check({nm, "_code"}, code, 2'd0);
   endtask

   task automatic issue_start(input int ntxn);
      start = 1'b1;
      step();
      start   = 1'b0;
      hs_idx  = 0;
      low_cnt = 0;
      vh_cnt  = 0;
      check("start_valid", valid, 1'b1);
      check("start_busy", busy, 1'b1);
      check("start_done", done, 1'b0);
      check("start_error", error, 1'b0);
      check("start_code", code, 2'd0);
      check("start_queue", exp_q.size(), ntxn);
   endtask

   task automatic run(input int wmode, input int err_at, input int nnz, input bit busy_start);
      int nreads, total, ntxn, outc, cyc;
      bit pulsed;
      cfg_wmode  = wmode;
      cfg_err_at = err_at;
      cfg_nnz    = nnz;
      nreads = (nnz < Polls) ? nnz + 1 : Polls;
      total  = 6 + nreads;
      if (err_at >= 0 && err_at < total) begin
         ntxn = err_at + 1;
         outc = 1;
      end else begin
         ntxn = total;
         outc = (nnz < Polls) ? 0 : 2;
      end
      exp_q.delete();
      for (int i = 0; i < ntxn; i++) exp_q.push_back(model_txn(i));
      issue_start(ntxn);
      cyc    = 0;
      pulsed = 1'b0;
      while (!(done || error) && cyc < 3000) begin
         start = busy_start && !pulsed && hs_idx == 3;
         if (start) pulsed = 1'b1;
         step();
         start = 1'b0;
         cyc++;
      end
      if (cyc >= 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL run_timeout: got no done/error after %0d cycles, expected completion", cyc);
      end
      if (wmode == 0) check("latency", cyc, ntxn + ((ntxn >= 6) ? Wait : 0));
      check("end_done", done, outc == 0);
      check("end_error", error, outc != 0);
      check("end_code", code, outc);
      check("end_busy", busy, 1'b0);
      check("end_valid", valid, 1'b0);
      if (wmode >= 0) check("valid_cycles", vh_cnt, ntxn * (wmode + 1));
      repeat (3) step();
      check("quiet_valid", valid, 1'b0);
      check("hold_done", done, outc == 0);
      check("pending_txns", exp_q.size(), 0);
   endtask

   task automatic run_reset_abort();
      int cyc;
      cfg_wmode  = 0;
      cfg_err_at = -1;
      cfg_nnz    = 0;
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(model_txn(i));
      issue_start(7);
      cyc = 0;
      while (hs_idx < 5 && cyc < 500) begin
         step();
         cyc++;
      end
      repeat (10) step();
      check("abort_in_wait", busy, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset("abort");
      exp_q.delete();
      repeat (60) step();
      check("abort_idle_valid", valid, 1'b0);
      check("abort_idle_busy", busy, 1'b0);
      check("abort_idle_done", done, 1'b0);
   endtask

   initial begin
      int wsel, ea;
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      err   = 1'b0;
      rdata = '0;
      repeat (2) step();
      check_reset("reset");
      rst_n = 1'b1;
      step();
      check("idle_valid", valid, 1'b0);

      run(0, -1, 0, 1'b0);          // zero-wait nominal
      run(3, -1, 0, 1'b0);          // 3 wait states per txn
      run(0, -1, Polls - 1, 1'b0);  // last allowed poll reads clear
      run(0, 2, 0, 1'b0);           // bus error on 0x303 write
      run(0, -1, 0, 1'b0);          // restart after error
      run(0, -1, 1000, 1'b0);       // ISOLATED stuck -> timeout
      run_reset_abort();
      run(0, -1, 0, 1'b1);          // start while busy is ignored

      for (int k = 0; k < 8; k++) begin
         wsel = int'($urandom_range(0, 3));
         ea   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
         run((wsel == 3) ? -1 : wsel, ea, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
